// File: rtl/vecmat_feed_pkg.sv
// Shared definitions for the vector/matrix feeder in front of the
// 64-lane dot-product engine: default geometry, the control state
// encoding and a small width helper.
package vecmat_feed_pkg;

    localparam int DEF_LANES      = 64;
    localparam int DEF_DW         = 16;
    localparam int DEF_ENG_LAT    = 3;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_ROW_W      = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_Q = 2'd1,
        LOAD_K = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    // Width of a counter able to hold the value max_val.
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1) + 1;
    endfunction

endpackage

// File: rtl/vecmat_score_fifo.sv
// Synchronous first-word-fall-through FIFO holding tagged scores.
// The head entry is visible on dout whenever empty is low; a push and
// a pop in the same cycle both take effect and leave count unchanged.
module vecmat_score_fifo
    import vecmat_feed_pkg::*;
#(
    parameter int W     = 27,
    parameter int DEPTH = 4
)(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_rd;
    logic          w_wr;

    // A pop needs data; a push is refused only when full without a pop.
    assign w_rd = pop && (r_count != (AW+1)'(0));
    assign w_wr = push && ((r_count != (AW+1)'(DEPTH)) || w_rd);

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents behind the pointers need no reset.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign empty = (r_count == (AW+1)'(0));
    assign full  = (r_count == (AW+1)'(DEPTH));

endmodule

// File: rtl/vecmat_feed.sv
// Front-end for the dot-product engine. Packs a serial element stream
// into the query vector and one K row at a time, issues each completed
// row to the engine, follows the engine's fixed latency to capture each
// result, and returns row-indexed scores through a small FWFT FIFO.
// A row is only allowed to complete when a FIFO slot is guaranteed for
// its result, so no score is ever dropped under consumer backpressure.
module vecmat_feed
    import vecmat_feed_pkg::*;
#(
    parameter int LANES      = DEF_LANES,
    parameter int DW         = DEF_DW,
    parameter int ENG_LAT    = DEF_ENG_LAT,   // must be >= 2
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int ROW_W      = DEF_ROW_W
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ROW_W-1:0]      num_rows,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DW-1:0]         in_data,
    output logic [LANES*DW-1:0]   vector,
    output logic [LANES*DW-1:0]   matrix,
    input  logic [DW-1:0]         eng_data,
    output logic                  score_valid,
    input  logic                  score_ready,
    output logic [DW-1:0]         score_data,
    output logic [ROW_W-1:0]      score_idx,
    output logic                  score_last,
    output logic                  busy,
    output logic                  done
);

    localparam int LW   = $clog2(LANES);
    localparam int CW   = $clog2(FIFO_DEPTH) + 1;
    localparam int FW   = DW + ROW_W + 1;
    localparam int SUMW = cnt_width(ENG_LAT + FIFO_DEPTH + 1);

    state_t                   r_state;
    state_t                   w_next_state;
    logic [LW-1:0]            r_lane;
    logic [ROW_W-1:0]         r_row;
    logic [ROW_W-1:0]         r_num_rows;
    logic [ROW_W-1:0]         r_push_idx;
    logic [LANES*DW-1:0]      r_vector;
    logic [(LANES-1)*DW-1:0]  r_stage;
    logic [LANES*DW-1:0]      r_matrix;
    logic                     r_issue;
    logic [ENG_LAT-1:0]       r_vld;
    logic                     r_done;

    logic                     w_in_ready;
    logic                     w_busy;
    logic                     w_accept;
    logic                     w_lane_last;
    logic                     w_row_last;
    logic [SUMW-1:0]          w_inflight;
    logic [SUMW-1:0]          w_commit;
    logic                     w_credit_ok;
    logic                     w_drain_clear;
    logic                     w_push;
    logic                     w_pop;
    logic [FW-1:0]            w_fifo_din;
    logic [FW-1:0]            w_fifo_dout;
    logic [CW-1:0]            w_fifo_count;
    logic                     w_fifo_empty;
    logic                     w_fifo_full;
    logic                     w_tag_last;

    // Number of results currently travelling through the engine.
    function automatic logic [SUMW-1:0] popcount(input logic [ENG_LAT-1:0] bits);
        logic [SUMW-1:0] acc;
        acc = '0;
        for (int i = 0; i < ENG_LAT; i++) begin
            acc = acc + SUMW'(bits[i]);
        end
        return acc;
    endfunction

    assign w_lane_last = (r_lane == LW'(LANES - 1));
    assign w_row_last  = (r_row == (r_num_rows - ROW_W'(1)));
    assign w_accept    = in_valid && w_in_ready;

    // Every committed result (in engine, buffered, or just issued) owns a
    // FIFO slot; a new row may only complete while a slot is still free.
    assign w_inflight    = popcount(r_vld);
    assign w_commit      = w_inflight + SUMW'(w_fifo_count) + SUMW'(r_issue);
    assign w_credit_ok   = !w_fifo_full && (w_commit < SUMW'(FIFO_DEPTH));
    assign w_drain_clear = (w_inflight == SUMW'(0)) && w_fifo_empty && !r_issue;

    // Control state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = LOAD_Q;
                end else begin
                    w_next_state = IDLE;
                end
            end
            LOAD_Q: begin
                if (w_accept && w_lane_last) begin
                    if (r_num_rows == ROW_W'(0)) begin
                        w_next_state = DRAIN;
                    end else begin
                        w_next_state = LOAD_K;
                    end
                end else begin
                    w_next_state = LOAD_Q;
                end
            end
            LOAD_K: begin
                if (w_accept && w_lane_last && w_row_last) begin
                    w_next_state = DRAIN;
                end else begin
                    w_next_state = LOAD_K;
                end
            end
            DRAIN: begin
                if (w_drain_clear) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = DRAIN;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // State-decoded handshake and status outputs.
    always_comb begin
        w_in_ready = 1'b0;
        w_busy     = 1'b1;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b0;
                w_busy     = 1'b0;
            end
            LOAD_Q: begin
                w_in_ready = 1'b1;
            end
            LOAD_K: begin
                // Only the row-completing element waits for credit.
                w_in_ready = !w_lane_last || w_credit_ok;
            end
            DRAIN: begin
                w_in_ready = 1'b0;
            end
            default: begin
                w_in_ready = 1'b0;
                w_busy     = 1'b0;
            end
        endcase
    end

    // One-cycle job-end pulse, raised as the FSM leaves DRAIN.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_done <= 1'b0;
        end else if ((r_state == DRAIN) && w_drain_clear) begin
            r_done <= 1'b1;
        end else begin
            r_done <= 1'b0;
        end
    end

    // Lane and row counters; the job length is latched at start.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_lane     <= '0;
            r_row      <= '0;
            r_num_rows <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_num_rows <= num_rows;
            r_lane     <= '0;
            r_row      <= '0;
        end else if (w_accept) begin
            r_lane <= w_lane_last ? LW'(0) : (r_lane + LW'(1));
            if ((r_state == LOAD_K) && w_lane_last) begin
                r_row <= r_row + ROW_W'(1);
            end
        end
    end

    // Query vector assembly, written in place lane by lane.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_vector <= '0;
        end else if ((r_state == LOAD_Q) && w_accept) begin
            r_vector[r_lane*DW +: DW] <= in_data;
        end
    end

    // K row staging; the final element lands straight in the issued row
    // so the engine sees a complete row in a single step.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stage  <= '0;
            r_matrix <= '0;
            r_issue  <= 1'b0;
        end else begin
            r_issue <= 1'b0;
            if ((r_state == LOAD_K) && w_accept) begin
                if (w_lane_last) begin
                    r_matrix <= {in_data, r_stage};
                    r_issue  <= 1'b1;
                end else begin
                    r_stage[r_lane*DW +: DW] <= in_data;
                end
            end
        end
    end

    // Issue delay line matching the engine latency.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_vld <= '0;
        end else begin
            r_vld <= {r_vld[ENG_LAT-2:0], r_issue};
        end
    end

    // Results return in issue order, so a running index tags each one.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_push_idx <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_push_idx <= '0;
        end else if (w_push) begin
            r_push_idx <= r_push_idx + ROW_W'(1);
        end
    end

    assign w_push     = r_vld[ENG_LAT-1];
    assign w_tag_last = (r_push_idx == (r_num_rows - ROW_W'(1)));
    assign w_fifo_din = {w_tag_last, eng_data, r_push_idx};
    assign w_pop      = !w_fifo_empty && score_ready;

    vecmat_score_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_score_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .din   (w_fifo_din),
        .pop   (w_pop),
        .dout  (w_fifo_dout),
        .count (w_fifo_count),
        .empty (w_fifo_empty),
        .full  (w_fifo_full)
    );

    assign in_ready    = w_in_ready;
    assign busy        = w_busy;
    assign done        = r_done;
    assign vector      = r_vector;
    assign matrix      = r_matrix;
    assign score_valid = !w_fifo_empty;
    assign score_last  = w_fifo_dout[FW-1];
    assign score_data  = w_fifo_dout[DW+ROW_W-1:ROW_W];
    assign score_idx   = w_fifo_dout[ROW_W-1:0];

endmodule
